// File: rtl/macros.sv
// Shared quantization helper and the default fraction-bit count for the I/Q reader.
package macros;

  localparam int BITS_DEFAULT = 10;

  // Sign-extend a 16-bit sample to 32 bits, then scale by 2**shift (truncating).
  function automatic logic [31:0] QUANTIZE(input logic [15:0] raw, input int unsigned shift);
    logic [31:0] ext;
    ext = {{16{raw[15]}}, raw};
    return ext << shift;
  endfunction

endpackage

// File: rtl/read_iq.sv
// Assembles little-endian I/Q byte quads from a FWFT byte FIFO into quantized samples.
// Writes I and Q together one cycle after the Q-high pop; stalls on empty input or either full output.
module read_iq
  import macros::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_dout,
  input  logic        in_empty,
  output logic        in_rd_en,
  output logic [31:0] i_out,
  output logic [31:0] q_out,
  output logic        i_wr_en,
  output logic        q_wr_en,
  input  logic        i_full,
  input  logic        q_full,
  output logic [31:0] sample_count
);

  typedef enum logic [2:0] {
    S_I_LO  = 3'd0,
    S_I_HI  = 3'd1,
    S_Q_LO  = 3'd2,
    S_Q_HI  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] i_lo, i_hi, q_lo, q_hi;
  logic       byte_state;
  logic       pop;
  logic       write;

  always_comb begin
    byte_state = (state == S_I_LO) || (state == S_I_HI) ||
                 (state == S_Q_LO) || (state == S_Q_HI);
    // Gate with reset so nothing leaves the block while it is held in reset.
    pop        = !reset && byte_state && !in_empty;
    write      = !reset && (state == S_WRITE) && !i_full && !q_full;
  end

  assign in_rd_en = pop;
  assign i_wr_en  = write;
  assign q_wr_en  = write;
  assign i_out    = write ? QUANTIZE({i_hi, i_lo}, BITS) : 32'd0;
  assign q_out    = write ? QUANTIZE({q_hi, q_lo}, BITS) : 32'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_I_LO;
      i_lo         <= 8'd0;
      i_hi         <= 8'd0;
      q_lo         <= 8'd0;
      q_hi         <= 8'd0;
      sample_count <= 32'd0;
    end else begin
      case (state)
        S_I_LO: if (!in_empty) begin
          i_lo  <= in_dout;
          state <= S_I_HI;
        end
        S_I_HI: if (!in_empty) begin
          i_hi  <= in_dout;
          state <= S_Q_LO;
        end
        S_Q_LO: if (!in_empty) begin
          q_lo  <= in_dout;
          state <= S_Q_HI;
        end
        S_Q_HI: if (!in_empty) begin
          q_hi  <= in_dout;
          state <= S_WRITE;
        end
        S_WRITE: if (!i_full && !q_full) begin
          sample_count <= sample_count + 32'd1;
          state        <= S_I_LO;
        end
        default: state <= S_I_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_read_iq.sv
// Randomized scoreboard bench for read_iq: FWFT byte source model, throttled sample sinks.
module tb_read_iq;

  localparam int BITS = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_dout = 8'd0;
  logic        in_empty = 1'b1;
  logic        in_rd_en;
  logic [31:0] i_out, q_out;
  logic        i_wr_en, q_wr_en;
  logic        i_full = 1'b0;
  logic        q_full = 1'b0;
  logic [31:0] sample_count;

  read_iq #(.BITS(BITS)) dut (
    .clock(clock), .reset(reset),
    .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .i_out(i_out), .q_out(q_out), .i_wr_en(i_wr_en), .q_wr_en(q_wr_en),
    .i_full(i_full), .q_full(q_full), .sample_count(sample_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Byte source contents: each byte carries a number of empty cycles shown before it.
  logic [7:0]  bq_byte[$];
  int          bq_stall[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_q[$];

  bit full_rand = 0;
  int q_full_hold = 0;

  // Monitor state
  int cyc = 0;
  int nbytes = 0;
  bit armed = 0;
  int exp_cnt = 0;
  int first_pop = 0;
  int last_span = 0;
  int last_wr_cyc = -100;
  bit have_prev = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [7:0] lo, input logic [7:0] hi);
    int s;
    s = int'($signed({hi, lo}));
    return 32'(s * (1 << BITS));
  endfunction

  task automatic push_byte(input logic [7:0] b, input int stall);
    bq_byte.push_back(b);
    bq_stall.push_back(stall);
  endtask

  task automatic push_pair_k(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input int stall2,
                             input logic [31:0] ei, input logic [31:0] eq);
    push_byte(b0, 0);
    push_byte(b1, 0);
    push_byte(b2, stall2);
    push_byte(b3, 0);
    exp_i.push_back(ei);
    exp_q.push_back(eq);
  endtask

  task automatic push_pair_rand();
    logic [7:0] b[4];
    for (int k = 0; k < 4; k++) begin
      b[k] = 8'($urandom);
      push_byte(b[k], ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    exp_i.push_back(model(b[0], b[1]));
    exp_q.push_back(model(b[2], b[3]));
  endtask

  // Driver: presents the source front byte (FWFT) and sink full flags each cycle.
  always begin
    @(negedge clock);
    if (bq_byte.size() > 0 && bq_stall[0] > 0) begin
      bq_stall[0] = bq_stall[0] - 1;
      in_empty = 1'b1;
      in_dout  = 8'($urandom);
    end else if (bq_byte.size() > 0) begin
      in_empty = 1'b0;
      in_dout  = bq_byte[0];
    end else begin
      in_empty = 1'b1;
      in_dout  = 8'($urandom);
    end
    if (full_rand) begin
      i_full = ($urandom_range(0, 3) == 0);
      q_full = ($urandom_range(0, 3) == 0);
    end else if (armed && q_full_hold > 0) begin
      i_full = 1'b0;
      q_full = 1'b1;
      q_full_hold--;
    end else begin
      i_full = 1'b0;
      q_full = 1'b0;
    end
    #3;
    if (in_rd_en && bq_byte.size() > 0) begin
      void'(bq_byte.pop_front());
      void'(bq_stall.pop_front());
    end
  end

  // Monitor: protocol checks every cycle, scoreboard compare on each write.
  always begin
    logic [31:0] ei, eq;
    @(negedge clock);
    #3;
    cyc++;
    if (reset) begin
      check("reset_rd_en", {31'd0, in_rd_en}, 32'd0);
      check("reset_wr_en", {30'd0, i_wr_en, q_wr_en}, 32'd0);
      check("reset_i_out", i_out, 32'd0);
      check("reset_q_out", q_out, 32'd0);
      check("reset_count", sample_count, 32'd0);
      nbytes = 0;
      armed = 0;
      exp_cnt = 0;
      have_prev = 0;
    end else begin
      check("wr_lockstep", {31'd0, q_wr_en}, {31'd0, i_wr_en});
      if (in_empty) check("rd_when_empty", {31'd0, in_rd_en}, 32'd0);
      if (armed) begin
        check("rd_in_write", {31'd0, in_rd_en}, 32'd0);
        if (i_full || q_full) check("wr_while_full", {31'd0, i_wr_en}, 32'd0);
        else check("wr_when_ready", {31'd0, i_wr_en}, 32'd1);
      end else begin
        check("wr_unexpected", {31'd0, i_wr_en}, 32'd0);
      end
      if (i_wr_en) begin
        if (exp_i.size() == 0) begin
          check("write_without_expected_pair", 32'd1, 32'd0);
        end else begin
          ei = exp_i.pop_front();
          eq = exp_q.pop_front();
          check("i_out", i_out, ei);
          check("q_out", q_out, eq);
        end
        check("count_before_write", sample_count, 32'(exp_cnt));
        if (have_prev) check("min_5_cycles_per_pair", {31'd0, (cyc - last_wr_cyc) >= 5}, 32'd1);
        exp_cnt++;
        have_prev = 1;
        last_wr_cyc = cyc;
        last_span = cyc - first_pop;
        armed = 0;
        nbytes = 0;
      end else begin
        check("idle_i_out_zero", i_out, 32'd0);
        check("idle_q_out_zero", q_out, 32'd0);
      end
      if (in_rd_en) begin
        if (nbytes == 0) first_pop = cyc;
        nbytes++;
        if (nbytes == 4) armed = 1;
      end
    end
  end

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while ((bq_byte.size() > 0 || exp_i.size() > 0 || armed || nbytes != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    check({"drain_timeout_", name}, {31'd0, n >= budget}, 32'd0);
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #3;
    check("post_reset_count", sample_count, 32'd0);
    check("post_reset_rd_en_idle", {31'd0, in_rd_en}, 32'd0);

    // Basic pair, unthrottled: 5 cycles from first pop to write inclusive.
    push_pair_k(8'h34, 8'h12, 8'h78, 8'h56, 0, 32'h0048D000, 32'h0159E000);
    drain(100, "basic");
    check("basic_count", sample_count, 32'd1);
    check("basic_span", 32'(last_span), 32'd4);

    // Sign extension of negative samples.
    push_pair_k(8'h00, 8'h80, 8'hFF, 8'hFF, 0, 32'hFE000000, 32'hFFFFFC00);
    drain(100, "sign");
    check("sign_count", sample_count, 32'd2);

    // Three empty cycles between I-high and Q-low: same result, span grows by 3.
    push_pair_k(8'h34, 8'h12, 8'h78, 8'h56, 3, 32'h0048D000, 32'h0159E000);
    drain(100, "empty_gap");
    check("empty_gap_span", 32'(last_span), 32'd7);

    // q_full for 4 cycles in the write state: write lands on the first non-full cycle.
    q_full_hold = 4;
    push_pair_k(8'hCD, 8'hAB, 8'h01, 8'h00, 0, model(8'hCD, 8'hAB), 32'h00000400);
    drain(100, "q_full");
    check("q_full_span", 32'(last_span), 32'd8);
    check("q_full_hold_used", 32'(q_full_hold), 32'd0);

    // Reset after two bytes: the partial pair is discarded.
    push_byte(8'hEE, 0);
    push_byte(8'hDD, 0);
    n = 0;
    while (bq_byte.size() > 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("partial_pop_timeout", {31'd0, n >= 50}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    push_pair_k(8'h11, 8'h22, 8'h33, 8'h44, 0, model(8'h11, 8'h22), model(8'h33, 8'h44));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    drain(100, "mid_reset");
    check("mid_reset_count", sample_count, 32'd1);

    // 1000 random pairs with random empty and full throttling.
    pulse_reset(2);
    full_rand = 1;
    for (int p = 0; p < 1000; p++) push_pair_rand();
    drain(30000, "random");
    full_rand = 0;
    check("random_count", sample_count, 32'd1000);
    check("random_scoreboard_empty", 32'(exp_i.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
